// File: rtl/cdma_rx_scheduler_if.sv
// Despreader link (rx bit in, code select out) and packed-word valid/ready stream.
// master = scheduler side, slave = despreader/CPU-FIFO side.
interface cdma_rx_scheduler_if #(
    parameter int BITS_PER_WORD = 8
);
    logic                     rx_data;
    logic                     rx_valid;
    logic                     user_select;
    logic [BITS_PER_WORD-1:0] word_data;
    logic                     word_user;
    logic                     word_valid;
    logic                     word_ready;

    modport master (
        input  rx_data, rx_valid, word_ready,
        output user_select, word_data, word_user, word_valid
    );

    modport slave (
        output rx_data, rx_valid, word_ready,
        input  user_select, word_data, word_user, word_valid
    );
endinterface

// File: rtl/cdma_rx_scheduler.sv
// Time-shares a two-code despreader between users 0/1, packs bits per user (CDMA_SCHED_SYMCNT_EN adds symbol counters).
// Latency: a word is presented the cycle after its last bit arrives.
// Backpressure: one-entry output register; a word completing while it is held is dropped and flags overflow.
module cdma_rx_scheduler #(
    parameter int CHIPS_PER_SYM = 64,
    parameter int BITS_PER_WORD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [1:0]                 user_en,
    cdma_rx_scheduler_if.master        bus,
    output logic                       busy,
    output logic                       sync_err,
    output logic                       overflow,
    output logic [15:0]                sym_cnt0,
    output logic [15:0]                sym_cnt1
);
    localparam int CW  = (CHIPS_PER_SYM > 1) ? $clog2(CHIPS_PER_SYM) : 1;
    localparam int BCW = $clog2(BITS_PER_WORD + 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CHIPS_PER_SYM - 1);
    localparam logic [BCW-1:0] BITS_LAST = BCW'(BITS_PER_WORD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            user_select_q, user_select_d;
    logic                            prev_user_q, prev_user_d;
    logic [1:0][BITS_PER_WORD-1:0]   pk_dat_q, pk_dat_d;
    logic [1:0][BCW-1:0]             pk_cnt_q, pk_cnt_d;
    logic [BITS_PER_WORD-1:0]        word_data_q, word_data_d;
    logic                            word_user_q, word_user_d;
    logic                            word_valid_q, word_valid_d;
    logic                            sync_err_q, sync_err_d;
    logic                            overflow_q, overflow_d;
    logic [BITS_PER_WORD-1:0]        shifted;
    logic                            start_ok, wrap, capture, clr_pk, lowest_user;

    // stop beats start when both arrive together
    assign start_ok = (state_q == IDLE) && start && !stop && (user_en != 2'b00);
    assign wrap     = (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        user_select_d = user_select_q;
        prev_user_d   = prev_user_q;
        sync_err_d    = sync_err_q;
        overflow_d    = overflow_q;
        pk_dat_d      = pk_dat_q;
        pk_cnt_d      = pk_cnt_q;
        word_data_d   = word_data_q;
        word_user_d   = word_user_q;
        word_valid_d  = word_valid_q && !bus.word_ready;
        capture       = 1'b0;
        clr_pk        = 1'b0;
        lowest_user   = ~user_en[0];
        shifted       = {pk_dat_q[prev_user_q][BITS_PER_WORD-2:0], bus.rx_data};

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d       = SYNC;
                    cnt_d         = '0;
                    user_select_d = lowest_user;
                    sync_err_d    = 1'b0;
                    overflow_d    = 1'b0;
                    clr_pk        = 1'b1;
                end
            end
            SYNC: begin
                user_select_d = lowest_user;
                if (stop) begin
                    state_d = IDLE;
                end else if (bus.rx_valid) begin
                    // the aligning bit belongs to no tracked symbol and is discarded
                    state_d = RUN;
                    cnt_d   = CW'(1);
                end
            end
            RUN, DRAIN: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                if (bus.rx_valid != (cnt_q == '0)) begin
                    sync_err_d = 1'b1;
                    clr_pk     = 1'b1;
                    cnt_d      = '0;
                    state_d    = (state_q == DRAIN || stop) ? IDLE : SYNC;
                end else begin
                    if (bus.rx_valid) begin
                        capture = 1'b1;
                        if (state_q == DRAIN) state_d = IDLE;
                    end
                    // bit arriving at count 0 was despread with the code active before the wrap
                    if (wrap) begin
                        prev_user_d = user_select_q;
                        if (user_en == 2'b00) begin
                            state_d = IDLE;
                            clr_pk  = 1'b1;
                        end else if (user_en[~user_select_q]) begin
                            user_select_d = ~user_select_q;
                        end
                    end
                    if (stop && state_q == RUN && state_d == RUN) state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (pk_cnt_q[prev_user_q] == BITS_LAST) begin
                pk_dat_d[prev_user_q] = '0;
                pk_cnt_d[prev_user_q] = '0;
                if (word_valid_d) begin
                    overflow_d = 1'b1;
                end else begin
                    word_valid_d = 1'b1;
                    word_data_d  = shifted;
                    word_user_d  = prev_user_q;
                end
            end else begin
                pk_dat_d[prev_user_q] = shifted;
                pk_cnt_d[prev_user_q] = pk_cnt_q[prev_user_q] + 1'b1;
            end
        end
        if (clr_pk) begin
            pk_dat_d = '0;
            pk_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            user_select_q <= 1'b0;
            prev_user_q   <= 1'b0;
            pk_dat_q      <= '0;
            pk_cnt_q      <= '0;
            word_data_q   <= '0;
            word_user_q   <= 1'b0;
            word_valid_q  <= 1'b0;
            sync_err_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            user_select_q <= user_select_d;
            prev_user_q   <= prev_user_d;
            pk_dat_q      <= pk_dat_d;
            pk_cnt_q      <= pk_cnt_d;
            word_data_q   <= word_data_d;
            word_user_q   <= word_user_d;
            word_valid_q  <= word_valid_d;
            sync_err_q    <= sync_err_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef CDMA_SCHED_SYMCNT_EN
    logic [1:0][15:0] sym_cnt_q, sym_cnt_d;

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        if (start_ok) begin
            sym_cnt_d = '0;
        end else if (capture && sym_cnt_q[prev_user_q] != 16'hFFFF) begin
            sym_cnt_d[prev_user_q] = sym_cnt_q[prev_user_q] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sym_cnt_q <= '0;
        else     sym_cnt_q <= sym_cnt_d;
    end

    assign sym_cnt0 = sym_cnt_q[0];
    assign sym_cnt1 = sym_cnt_q[1];
`else
    assign sym_cnt0 = 16'h0000;
    assign sym_cnt1 = 16'h0000;
`endif

    assign bus.user_select = user_select_q;
    assign bus.word_data   = word_data_q;
    assign bus.word_user   = word_user_q;
    assign bus.word_valid  = word_valid_q;
    assign busy            = (state_q != IDLE);
    assign sync_err        = sync_err_q;
    assign overflow        = overflow_q;
endmodule

// File: tb/tb_cdma_rx_scheduler.sv
// Directed bench for cdma_rx_scheduler: despreader model emits one bit per 64-chip symbol,
// expected words go into a queue and are popped when the stream handshake completes.
module tb_cdma_rx_scheduler;
    localparam int BPW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  user_en = 2'b00;
    logic        busy, sync_err, overflow;
    logic [15:0] sym_cnt0, sym_cnt1;

    int          total = 0;
    int          bad = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_exp;
    logic [7:0]  w0, w1;
    int          exp_sc;

    cdma_rx_scheduler_if #(.BITS_PER_WORD(BPW)) bus ();

    cdma_rx_scheduler #(.CHIPS_PER_SYM(64), .BITS_PER_WORD(BPW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .user_en(user_en),
        .bus(bus), .busy(busy), .sync_err(sync_err), .overflow(overflow),
        .sym_cnt0(sym_cnt0), .sym_cnt1(sym_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard pop on every accepted word; an unexpected word compares against X
    always @(negedge clk) begin
        if (!rst && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
            chk("word_out", {23'd0, bus.word_user, bus.word_data}, {23'd0, mon_exp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic b, input logic vld, input int stop_at);
        bus.rx_valid = vld;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 1'b0;
        for (int i = 0; i < 63; i++) begin
            stop = (i == stop_at);
            tick();
        end
        stop = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_sym(w[i], 1'b1, -1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_word_valid"}, {31'd0, bus.word_valid}, 32'd0);
        chk({tag, "_word_data"}, {24'd0, bus.word_data}, 32'd0);
        chk({tag, "_word_user"}, {31'd0, bus.word_user}, 32'd0);
        chk({tag, "_user_select"}, {31'd0, bus.user_select}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sync_err"}, {31'd0, sync_err}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_sym_cnt"}, {sym_cnt1, sym_cnt0}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        bus.rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [1:0] en);
        user_en = en;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 1'b0;
        bus.word_ready = 1'b1;
        #12;
        check_zero("reset");
        rst = 1'b0;
        tick();

        // start ignored with no user enabled; stop beats start
        do_start(2'b00);
        chk("start_no_user", {31'd0, busy}, 32'd0);
        user_en = 2'b01;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("stop_beats_start", {31'd0, busy}, 32'd0);

        // single user 0, word 0xA5
        do_start(2'b01);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_sym(1'b0, 1'b1, -1);
        w0 = 8'hA5;
        exp_q.push_back({1'b0, w0});
        for (int i = 7; i >= 0; i--) begin
            chk("t1_user_select", {31'd0, bus.user_select}, 32'd0);
            send_sym(w0[i], 1'b1, -1);
        end
        chk("t1_words_left", exp_q.size(), 32'd0);
        do_reset();

        // both users alternate symbols
        do_start(2'b11);
        send_sym(1'b0, 1'b1, -1);
        chk("t2_sel_after_align", {31'd0, bus.user_select}, 32'd1);
        w0 = 8'h3C;
        w1 = 8'hC3;
        exp_q.push_back({1'b0, w0});
        exp_q.push_back({1'b1, w1});
        for (int i = 7; i >= 0; i--) begin
            send_sym(w0[i], 1'b1, -1);
            chk("t2_sel_u0_sym", {31'd0, bus.user_select}, 32'd0);
            send_sym(w1[i], 1'b1, -1);
            chk("t2_sel_u1_sym", {31'd0, bus.user_select}, 32'd1);
        end
        chk("t2_words_left", exp_q.size(), 32'd0);
        do_reset();

        // held output register, second word dropped
        bus.word_ready = 1'b0;
        do_start(2'b01);
        send_sym(1'b0, 1'b1, -1);
        w0 = 8'h5A;
        w1 = 8'h81;
        exp_q.push_back({1'b0, w0});
        send_word(w0);
        chk("t3_first_valid", {31'd0, bus.word_valid}, 32'd1);
        chk("t3_first_data", {24'd0, bus.word_data}, {24'd0, w0});
        chk("t3_no_overflow_yet", {31'd0, overflow}, 32'd0);
        send_word(w1);
        chk("t3_held_valid", {31'd0, bus.word_valid}, 32'd1);
        chk("t3_held_data", {24'd0, bus.word_data}, {24'd0, w0});
        chk("t3_held_user", {31'd0, bus.word_user}, 32'd0);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        bus.word_ready = 1'b1;
        send_sym(1'b0, 1'b1, -1);
        chk("t3_valid_after_accept", {31'd0, bus.word_valid}, 32'd0);
        chk("t3_words_left", exp_q.size(), 32'd0);
        do_reset();
        chk("t3_overflow_cleared", {31'd0, overflow}, 32'd0);

        // missing rx_valid: sync error, partial lost, realign
        do_start(2'b01);
        send_sym(1'b0, 1'b1, -1);
        send_sym(1'b1, 1'b1, -1);
        send_sym(1'b1, 1'b1, -1);
        send_sym(1'b0, 1'b1, -1);
        send_sym(1'b1, 1'b0, -1);
        chk("t4_sync_err", {31'd0, sync_err}, 32'd1);
        chk("t4_busy_in_sync", {31'd0, busy}, 32'd1);
        send_sym(1'b0, 1'b1, -1);
        w0 = 8'h96;
        exp_q.push_back({1'b0, w0});
        send_word(w0);
        chk("t4_words_left", exp_q.size(), 32'd0);
        chk("t4_sync_err_sticky", {31'd0, sync_err}, 32'd1);

        // stop after 5 bits: drain takes bit 6, no word
        for (int i = 0; i < 4; i++) send_sym(1'b1, 1'b1, -1);
        send_sym(1'b1, 1'b1, 30);
        chk("t5_busy_drain", {31'd0, busy}, 32'd1);
        send_sym(1'b1, 1'b1, -1);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        chk("t5_no_word", {31'd0, bus.word_valid}, 32'd0);
        chk("t5_sync_err_kept", {31'd0, sync_err}, 32'd1);
        do_start(2'b01);
        chk("t5_start_clears_err", {31'd0, sync_err}, 32'd0);
        do_reset();

        // symbol counters over 10 alternating symbols
        do_start(2'b11);
        send_sym(1'b0, 1'b1, -1);
        for (int i = 0; i < 10; i++) send_sym(i[0], 1'b1, -1);
`ifdef CDMA_SCHED_SYMCNT_EN
        exp_sc = 5;
`else
        exp_sc = 0;
`endif
        chk("t6_sym_cnt0", {16'd0, sym_cnt0}, exp_sc);
        chk("t6_sym_cnt1", {16'd0, sym_cnt1}, exp_sc);
        chk("t6_words_left", exp_q.size(), 32'd0);
        do_reset();

        // asynchronous reset with a pending word from user 1
        bus.word_ready = 1'b0;
        do_start(2'b10);
        send_sym(1'b0, 1'b1, -1);
        chk("t7_sel_user1", {31'd0, bus.user_select}, 32'd1);
        w0 = 8'hFF;
        send_word(w0);
        chk("t7_pending_valid", {31'd0, bus.word_valid}, 32'd1);
        chk("t7_pending_word", {23'd0, bus.word_user, bus.word_data}, {23'd0, 1'b1, w0});
        #3;
        rst = 1'b1;
        #1;
        check_zero("t7_async_rst");
        tick();
        rst = 1'b0;
        bus.word_ready = 1'b1;
        tick();
        chk("final_words_left", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
